slot_fifo_arbiter: RTL and testbench

//  Shares one byte-wide sample-FIFO write port between N_SLOTS slot data sources (ADC-type slot modules).

---
 rtl/slot_fifo_arbiter_pkg.sv | 30 +++
 rtl/slot_fifo_arbiter_if.sv | 27 ++
 rtl/slot_fifo_arbiter_rr.sv | 34 +++
 rtl/slot_fifo_arbiter.sv | 123 ++++++++++++
 tb/tb_slot_fifo_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_fifo_arbiter_pkg.sv
// Shared types and constants for the slot-to-FIFO packet arbiter.
package slot_fifo_arbiter_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned PKT_BYTES = 5;

  localparam logic [BYTE_W-1:0] HDR_MARKER = 8'h80;

  // Each non-idle state names the next data byte to emit.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              write;
  } fifo_wr_t;

  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        sel);
    return w[BYTE_W*sel +: BYTE_W];
  endfunction

endpackage

// File: rtl/slot_fifo_arbiter_if.sv
// Slot request/word bus plus FIFO write port and status seen by the arbiter.
interface slot_fifo_arbiter_if #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned ADDR_W  = 11
);
  logic                   enable;
  logic [N_SLOTS-1:0]     slot_req;
  logic [32*N_SLOTS-1:0]  slot_word;
  logic [N_SLOTS-1:0]     slot_ack;
  logic [7:0]             fifo_data;
  logic                   fifo_write;
  logic [ADDR_W-1:0]      fifo_addr_in;
  logic [ADDR_W-1:0]      fifo_addr_out;
  logic                   busy;
  logic [2:0]             cur_slot;
  logic [31:0]            word_count;

  modport master (
    output enable, slot_req, slot_word, fifo_addr_in, fifo_addr_out,
    input  slot_ack, fifo_data, fifo_write, busy, cur_slot, word_count
  );

  modport slave (
    input  enable, slot_req, slot_word, fifo_addr_in, fifo_addr_out,
    output slot_ack, fifo_data, fifo_write, busy, cur_slot, word_count
  );
endinterface

// File: rtl/slot_fifo_arbiter_rr.sv
// Combinational round-robin select: first requester at or after ptr_i, ascending with wrap.
module rr_arbiter
  import slot_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]      req_i,
  input  logic [SLOT_W-1:0] ptr_i,
  output logic [N-1:0]      gnt_o,
  output logic [SLOT_W-1:0] idx_o,
  output logic              any_o
);

  logic [2*N-1:0]    req2;
  logic [N-1:0]      rot;
  logic [SLOT_W-1:0] off;
  logic [SLOT_W:0]   sum;

  // Rotate so the pointer slot sits at bit 0, find the first set bit, rotate back.
  always_comb begin
    req2 = {req_i, req_i};
    rot  = N'(req2 >> ptr_i);
    off  = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) off = SLOT_W'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (32'(sum) >= N) idx_o = SLOT_W'(32'(sum) - N);
    else               idx_o = SLOT_W'(sum);
    any_o = |req_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/slot_fifo_arbiter.sv
// Grants slot sources round-robin and serialises each 32-bit word as a 5-byte FIFO packet.
module slot_fifo_arbiter
  import slot_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned PTR_LAG = 2
) (
  input logic                clk,
  input logic                reset,
  slot_fifo_arbiter_if.slave bus
);

  localparam int unsigned SPACE_NEED = PKT_BYTES + PTR_LAG;

  state_e              state_q, state_d;
  fifo_wr_t            fifo_q, fifo_d;
  logic [N_SLOTS-1:0]  ack_q, ack_d;
  logic [SLOT_W-1:0]   cur_q, cur_d;
  logic [SLOT_W-1:0]   rr_q, rr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   used;
  logic [ADDR_W-1:0]   free;
  logic                space_ok;
  logic                grant;

  logic [N_SLOTS-1:0]  win_gnt;
  logic [SLOT_W-1:0]   win_idx;
  logic                win_any;

  rr_arbiter #(.N(N_SLOTS)) u_rr (
    .req_i (bus.slot_req),
    .ptr_i (rr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Modular pointer difference; free = depth-1-used is the bitwise complement of used.
  always_comb begin
    used     = bus.fifo_addr_in - bus.fifo_addr_out;
    free     = ~used;
    space_ok = (32'(free) >= 32'(SPACE_NEED));
    grant    = bus.enable & space_ok & win_any;
  end

  always_comb begin
    state_d     = state_q;
    fifo_d      = '0;
    ack_d       = '0;
    cur_d       = cur_q;
    rr_d        = rr_q;
    word_d      = word_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          word_d       = WORD_W'(bus.slot_word >> (WORD_W * win_idx));
          ack_d        = win_gnt;
          cur_d        = win_idx;
          rr_d         = (32'(win_idx) + 32'd1 >= N_SLOTS) ? '0 : win_idx + SLOT_W'(1);
          fifo_d.data  = HDR_MARKER | BYTE_W'(win_idx);
          fifo_d.write = 1'b1;
          state_d      = ST_B0;
        end
      end
      ST_B0: begin
        fifo_d  = '{data: word_byte(word_q, 2'd0), write: 1'b1};
        state_d = ST_B1;
      end
      ST_B1: begin
        fifo_d  = '{data: word_byte(word_q, 2'd1), write: 1'b1};
        state_d = ST_B2;
      end
      ST_B2: begin
        fifo_d  = '{data: word_byte(word_q, 2'd2), write: 1'b1};
        state_d = ST_B3;
      end
      ST_B3: begin
        fifo_d  = '{data: word_byte(word_q, 2'd3), write: 1'b1};
        cnt_d   = cnt_q + WORD_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      fifo_q  <= '0;
      ack_q   <= '0;
      cur_q   <= '0;
      rr_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      ack_q   <= ack_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.fifo_data  = fifo_q.data;
  assign bus.fifo_write = fifo_q.write;
  assign bus.slot_ack   = ack_q;
  assign bus.cur_slot   = cur_q;
  assign bus.word_count = cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_slot_fifo_arbiter.sv
// Bench for slot_fifo_arbiter: directed scenarios plus random traffic against a byte-queue model.
module tb_slot_fifo_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 11;
  localparam int unsigned LAG   = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  slot_fifo_arbiter_if #(.N_SLOTS(N), .ADDR_W(AW)) bus ();

  slot_fifo_arbiter #(.N_SLOTS(N), .ADDR_W(AW), .PTR_LAG(LAG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0]  words [N];
  logic [N-1:0] req;
  logic         en;
  int unsigned  a_in, a_out;
  int           policy;  // after ack: 0 drop, 1 hold with new word, 2 random

  // Reference model: pending packet bytes as a queue
  logic [7:0]   m_q[$];
  int           m_rr;
  int           m_cur;
  logic [31:0]  m_cnt;
  logic [7:0]   e_data;
  logic         e_wr;
  logic [N-1:0] e_ack;
  logic         e_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    logic [32*N-1:0] sw;
    for (int i = 0; i < int'(N); i++) sw[32*i +: 32] = words[i];
    bus.slot_word     = sw;
    bus.slot_req      = req;
    bus.enable        = en;
    bus.fifo_addr_in  = AW'(a_in);
    bus.fifo_addr_out = AW'(a_out);
  endtask

  task automatic model_step();
    int used, free, win, s;
    logic [31:0] w;
    if (!reset) begin
      m_q.delete();
      m_rr = 0; m_cur = 0; m_cnt = '0;
      e_data = '0; e_wr = 1'b0; e_ack = '0;
    end else if (m_q.size() != 0) begin
      e_data = m_q.pop_front();
      e_wr   = 1'b1;
      e_ack  = '0;
      if (m_q.size() == 0) m_cnt = m_cnt + 32'd1;
    end else begin
      used = int'((a_in + DEPTH - a_out) % DEPTH);
      free = int'(DEPTH) - 1 - used;
      win  = -1;
      if (en && free >= 5 + int'(LAG)) begin
        for (int k = 0; k < int'(N); k++) begin
          s = (m_rr + k) % int'(N);
          if (win < 0 && req[s]) win = s;
        end
      end
      if (win >= 0) begin
        w      = words[win];
        m_q    = '{w[7:0], w[15:8], w[23:16], w[31:24]};
        e_data = 8'h80 | 8'(win);
        e_wr   = 1'b1;
        e_ack  = N'(1) << win;
        m_cur  = win;
        m_rr   = (win + 1) % int'(N);
      end else begin
        e_data = '0; e_wr = 1'b0; e_ack = '0;
      end
    end
    e_busy = (m_q.size() != 0);
  endtask

  task automatic requester_update();
    for (int i = 0; i < int'(N); i++) begin
      if (e_ack[i]) begin
        if (policy == 0) req[i] = 1'b0;
        else if (policy == 1) begin req[i] = 1'b1; words[i] = $urandom; end
        else begin req[i] = 1'($urandom_range(0, 1)); words[i] = $urandom; end
      end else if (policy == 2 && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i]   = 1'b1;
        words[i] = $urandom;
      end
    end
  endtask

  // One clock: apply inputs, advance model, compare every output after the edge.
  task automatic step();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_eq("fifo_data",  32'(bus.fifo_data),  32'(e_data));
    check_eq("fifo_write", 32'(bus.fifo_write), 32'(e_wr));
    check_eq("slot_ack",   32'(bus.slot_ack),   32'(e_ack));
    check_eq("busy",       32'(bus.busy),       32'(e_busy));
    check_eq("cur_slot",   32'(bus.cur_slot),   32'(m_cur));
    check_eq("word_count", bus.word_count,      m_cnt);
    requester_update();
  endtask

  initial begin
    logic [7:0] t1b [4];
    int nw;
    int acks [N];
    int used;

    t1b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    en = 1'b0; req = '0; a_in = 0; a_out = 0; policy = 0;
    for (int i = 0; i < int'(N); i++) words[i] = '0;

    // Reset state
    reset = 1'b0;
    step(); step();
    check_eq("rst_write", 32'(bus.fifo_write), 32'd0);
    check_eq("rst_count", bus.word_count, 32'd0);
    reset = 1'b1;

    // Single request from slot 2
    words[2] = 32'hDEADBEEF; req = 4'b0100; en = 1'b1;
    step();
    check_eq("t1_hdr", 32'(bus.fifo_data), 32'h82);
    check_eq("t1_ack", 32'(bus.slot_ack), 32'h4);
    for (int b = 0; b < 4; b++) begin
      step();
      check_eq("t1_byte", 32'(bus.fifo_data), 32'(t1b[b]));
      check_eq("t1_ack_pulse", 32'(bus.slot_ack), 32'd0);
    end
    check_eq("t1_count", bus.word_count, 32'd1);
    step();
    check_eq("t1_idle", 32'(bus.fifo_write), 32'd0);

    // All slots requesting continuously: rotation with no gaps
    reset = 1'b0; step(); reset = 1'b1;
    policy = 1; req = '1;
    for (int i = 0; i < int'(N); i++) begin words[i] = $urandom; acks[i] = 0; end
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.fifo_write) nw++;
      for (int i = 0; i < int'(N); i++) if (bus.slot_ack[i]) acks[i]++;
      if (c % 5 == 0) check_eq("t2_hdr", 32'(bus.fifo_data), 32'h80 + 32'((c / 5) % 4));
    end
    check_eq("t2_writes", 32'(nw), 32'd20);
    for (int i = 0; i < int'(N); i++) check_eq("t2_acks", 32'(acks[i]), 32'd1);
    req = '0; policy = 0;
    step();
    check_eq("t2_stop", 32'(bus.fifo_write), 32'd0);

    // Free space exactly at threshold, then one short of it
    a_in = 2040; a_out = 0; req = 4'b0010; words[1] = $urandom;
    step();
    check_eq("t3_grant", 32'(bus.fifo_write), 32'd1);
    repeat (4) step();
    a_in = 2041; req = 4'b0010; words[1] = $urandom;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t3_hold_wr", 32'(bus.fifo_write), 32'd0);
      check_eq("t3_hold_ack", 32'(bus.slot_ack), 32'd0);
    end
    a_out = 1;
    step();
    check_eq("t3_release", 32'(bus.fifo_write), 32'd1);
    repeat (4) step();

    // Pointer wrap: used = 6
    a_in = 3; a_out = 2045; req = 4'b0001; words[0] = $urandom;
    step();
    check_eq("t4_wrap", 32'(bus.fifo_write), 32'd1);
    repeat (4) step();

    // Enable dropped after header
    a_in = 0; a_out = 0; req = 4'b1000; words[3] = $urandom; policy = 1;
    step();
    check_eq("t5_hdr", 32'(bus.fifo_data), 32'h83);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("t5_tail", 32'(bus.fifo_write), 32'd1);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("t5_nogrant", 32'(bus.fifo_write), 32'd0);
    end
    en = 1'b1;
    step();
    check_eq("t5_resume", 32'(bus.fifo_data), 32'h83);
    repeat (4) step();
    req = '0; policy = 0;

    // Reset during B1 aborts the packet; pointer returns to slot 0
    req = 4'b0100; words[2] = $urandom;
    step(); step();
    reset = 1'b0;
    step();
    check_eq("t6_write", 32'(bus.fifo_write), 32'd0);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_data", 32'(bus.fifo_data), 32'd0);
    reset = 1'b1; req = '1;
    for (int i = 0; i < int'(N); i++) words[i] = $urandom;
    step();
    check_eq("t6_first", 32'(bus.fifo_data), 32'h80);
    repeat (4) step();

    // Random traffic with free space hovering around the threshold
    policy = 2;
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) != 0);
      a_out = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: used = int'($urandom_range(0, 10));
        6, 7, 8:          used = int'($urandom_range(2036, 2047));
        default:          used = int'($urandom_range(0, DEPTH - 1));
      endcase
      a_in = (a_out + int'(used)) % DEPTH;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
